// File: rtl/seq_divider.sv
// seq_divider: sequential signed 16-by-8 restoring divider.
// The 16-bit dividend and 8-bit divisor are captured on start, reduced to
// magnitudes, divided by eight shift-subtract steps, then sign-corrected.
// The quotient truncates toward zero and the remainder takes the sign of
// the dividend. Results that cannot be represented in 8 bits raise ovf;
// a zero divisor raises divzero. Both of these return Q=R=0.
module seq_divider (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start,
    input  logic signed [15:0] IN1,
    input  logic signed [7:0]  IN2,
    output logic               busy,
    output logic               done,
    output logic signed [7:0]  Q,
    output logic signed [7:0]  R,
    output logic               divzero,
    output logic               ovf
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Captured operands.
    logic signed [15:0] dividend;
    logic signed [7:0]  divisor;

    // Magnitude-domain working registers.
    logic [8:0] dm;
    logic [8:0] rem;
    logic [7:0] quo;
    logic [2:0] cnt;
    logic       sn;
    logic       sd;

    // Combinational helpers.
    logic [8:0]  dm_c;
    logic [15:0] nm_c;
    logic        early_dz;
    logic        early_ovf;
    logic [9:0]  shift_c;
    logic        step_ge;
    logic [8:0]  rem_step;
    logic [7:0]  quo_step;
    logic        qs;
    logic        late_ovf;
    logic [7:0]  q_fix;
    logic [7:0]  r_fix;

    // Magnitude of an 8-bit two's complement value; -128 maps to 128.
    function automatic logic [8:0] mag9(input logic [7:0] v);
        logic [8:0] w;
        w = {v[7], v};
        mag9 = v[7] ? (~w + 9'd1) : w;
    endfunction

    // Magnitude of a 16-bit two's complement value; 0x8000 maps to 32768.
    function automatic logic [15:0] mag16(input logic [15:0] v);
        mag16 = v[15] ? (~v + 16'd1) : v;
    endfunction

    // Two's complement negation of an 8-bit value.
    function automatic logic [7:0] neg8(input logic [7:0] v);
        neg8 = ~v + 8'd1;
    endfunction

    // Operand preparation: magnitudes and early-exit detection.
    always_comb begin
        dm_c      = mag9(divisor);
        nm_c      = mag16(dividend);
        early_dz  = (dm_c == 9'd0);
        early_ovf = ({1'b0, nm_c[15:8]} >= dm_c);
    end

    // One restoring step: shift {rem,quo} left, subtract divisor if it fits.
    always_comb begin
        shift_c  = {rem, quo[7]};
        step_ge  = (shift_c >= {1'b0, dm});
        rem_step = step_ge ? (shift_c[8:0] - dm) : shift_c[8:0];
        quo_step = {quo[6:0], step_ge};
    end

    // Sign correction and final range check on the magnitude quotient.
    always_comb begin
        qs       = sn ^ sd;
        late_ovf = qs ? (quo > 8'd128) : (quo > 8'd127);
        q_fix    = qs ? neg8(quo) : quo;
        r_fix    = sn ? neg8(rem[7:0]) : rem[7:0];
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_PREP;
                end
            end
            S_PREP: begin
                busy = 1'b1;
                if (early_dz || early_ovf) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_ITER;
                end
            end
            S_ITER: begin
                busy = 1'b1;
                if (cnt == 3'd7) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture and shift-subtract datapath.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dividend <= '0;
            divisor  <= '0;
            dm       <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            sn       <= 1'b0;
            sd       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dividend <= IN1;
                        divisor  <= IN2;
                    end
                end
                S_PREP: begin
                    dm  <= dm_c;
                    sn  <= dividend[15];
                    sd  <= divisor[7];
                    rem <= {1'b0, nm_c[15:8]};
                    quo <= nm_c[7:0];
                    cnt <= 3'd0;
                end
                S_ITER: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: loaded only on the transition into DONE.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            Q       <= '0;
            R       <= '0;
            divzero <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (state == S_PREP && (early_dz || early_ovf)) begin
                Q       <= '0;
                R       <= '0;
                divzero <= early_dz;
                ovf     <= ~early_dz;
            end else if (state == S_FIX) begin
                divzero <= 1'b0;
                ovf     <= late_ovf;
                Q       <= late_ovf ? 8'h00 : q_fix;
                R       <= late_ovf ? 8'h00 : r_fix;
            end
        end
    end

endmodule
